// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register interface: frame geometry and FSM states.
package spi_reg_pkg;
  localparam int FRAME_BITS = 16;
  localparam int BYTE_BITS  = 8;
  localparam int ADDR_BITS  = 8;
  localparam int RW_BIT     = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    WAIT_CS = 2'd3
  } state_t;
endpackage

// File: rtl/spi_reg_if_if.sv
// SPI pins plus register-file bus for spi_reg_if, bundled into one interface.
interface spi_reg_if_if;
  import spi_reg_pkg::*;

  logic                 sclk_i;
  logic                 cs_n_i;
  logic                 mosi_i;
  logic                 miso_o;
  logic [ADDR_BITS-1:0] addr_o;
  logic [BYTE_BITS-1:0] data_o;
  logic                 wr_en_o;
  logic [BYTE_BITS-1:0] rd_data_i;
  logic                 addr_err_o;

  modport slave (
    input  sclk_i, cs_n_i, mosi_i, rd_data_i,
    output miso_o, addr_o, data_o, wr_en_o, addr_err_o
  );

  modport master (
    output sclk_i, cs_n_i, mosi_i, rd_data_i,
    input  miso_o, addr_o, data_o, wr_en_o, addr_err_o
  );
endinterface

// File: rtl/spi_reg_if_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input; STAGES must be >= 2.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff_q;

  // shift the raw input through the flop chain; reset presets the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= {STAGES{RST_VAL}};
    else        ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/spi_reg_if.sv
// SPI mode-0 slave that turns 16-bit frames {rw, addr[6:0]}, data into register
// writes. All SPI inputs are oversampled on clk after synchronization.
// Optional macro SPI_READBACK_EN: read frames shift rd_data_i out on miso_o.
module spi_reg_if
  import spi_reg_pkg::*;
#(
  parameter int MAX_ADDR    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_if_if.slave    bus
);
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d_q, cs_d_q;
  logic rise, cs_fall;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [6:0]           sr_q, sr_d;
  logic [BYTE_BITS-1:0] byte_w;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic                 done_q, done_d;
  logic [BYTE_BITS-1:0] byte_q, byte_d;
  logic [BYTE_BITS-1:0] data_q;
  logic                 wr_en_q, err_q;
  logic                 in_range;
  logic                 wr_ok;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(bus.sclk_i), .q_o(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n_i), .q_o(cs_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(bus.mosi_i), .q_o(mosi_s));

  // one-cycle delayed copies for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d_q <= 1'b0;
      cs_d_q   <= 1'b1;
    end else begin
      sclk_d_q <= sclk_s;
      cs_d_q   <= cs_s;
    end
  end

  assign rise    = sclk_s & ~sclk_d_q;
  assign cs_fall = ~cs_s & cs_d_q;
  // the byte completed by the current rising edge (7 held bits + incoming bit)
  assign byte_w  = {sr_q, mosi_s};
  assign in_range = (int'(addr_q) < MAX_ADDR);

  // frame FSM: count rising edges, capture byte0 after 8, byte1 after 16
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    done_d  = 1'b0;
    byte_d  = byte_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cs_fall) state_d = ADDR;
      end
      ADDR: if (rise) begin
        sr_d  = byte_w[6:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(BYTE_BITS - 1)) begin
          state_d = DATA;
          addr_d  = {1'b0, byte_w[6:0]};
          rw_d    = byte_w[RW_BIT];
        end
      end
      DATA: if (rise) begin
        sr_d  = byte_w[6:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(FRAME_BITS - 1)) begin
          state_d = WAIT_CS;
          done_d  = 1'b1;
          byte_d  = byte_w;
        end
      end
      default: ;
    endcase
    // chip select high aborts whatever frame is in flight
    if (cs_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // FSM and frame capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
      byte_q  <= byte_d;
    end
  end

  assign wr_ok = done_q & ~rw_q & in_range;

  // register-file side: write strobe / error pulse one cycle after frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= wr_ok;
      if (wr_ok) data_q <= byte_q;
`ifdef SPI_READBACK_EN
      err_q   <= done_q & ~in_range;
`else
      err_q   <= done_q & ~in_range & ~rw_q;
`endif
    end
  end

`ifdef SPI_READBACK_EN
  logic                 fall;
  logic                 load_d, load_q;
  logic [BYTE_BITS-1:0] tx_q;

  assign fall   = ~sclk_s & sclk_d_q;
  assign load_d = (state_q == ADDR) && (state_d == DATA) && byte_w[RW_BIT];

  // TX shifter: load after byte0 (addr_o already valid), shift on falls after the 9th rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      tx_q   <= '0;
    end else begin
      load_q <= load_d;
      if (state_q == IDLE)
        tx_q <= '0;
      else if (load_q)
        tx_q <= in_range ? bus.rd_data_i : '0;
      else if (fall && state_q == DATA && cnt_q > 5'(BYTE_BITS))
        tx_q <= {tx_q[BYTE_BITS-2:0], 1'b0};
    end
  end

  assign bus.miso_o = tx_q[BYTE_BITS-1];
`else
  assign bus.miso_o = 1'b0;
`endif

  assign bus.addr_o     = addr_q;
  assign bus.data_o     = data_q;
  assign bus.wr_en_o    = wr_en_q;
  assign bus.addr_err_o = err_q;
endmodule

// File: tb/tb_spi_reg_if.sv
// Directed + random bench for spi_reg_if with a scoreboard of expected strobes.
module tb_spi_reg_if;
  import spi_reg_pkg::*;

  localparam int MAX_ADDR = 8;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic       err;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         vec = 0;
  int         miscmp = 0;
  ev_t        q[$];
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_data = 8'h00;

  spi_reg_if_if bus();

  spi_reg_if #(.MAX_ADDR(MAX_ADDR), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every strobe must match the oldest expected event, including its cycle
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (bus.wr_en_o || bus.addr_err_o)) begin
      vec++;
      assert (q.size() != 0) else begin
        miscmp++;
        $error("FAIL pulse_unexpected got wr=%b err=%b addr=%h data=%h cyc=%0d expected no pulse",
               bus.wr_en_o, bus.addr_err_o, bus.addr_o, bus.data_o, cyc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        vec++;
        assert (bus.wr_en_o === e.wr && bus.addr_err_o === e.err && bus.addr_o === e.addr &&
                bus.data_o === e.data && cyc == e.cyc) else begin
          miscmp++;
          $error("FAIL pulse got wr=%b err=%b addr=%h data=%h cyc=%0d expected wr=%b err=%b addr=%h data=%h cyc=%0d",
                 bus.wr_en_o, bus.addr_err_o, bus.addr_o, bus.data_o, cyc,
                 e.wr, e.err, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec++;
    assert (got === exp) else begin
      miscmp++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one frame of nbits (bits past 16 are 1s), model expected results
  task automatic frame(input logic [15:0] w, input int nbits);
    logic [7:0] tx;
    logic       b;
    bit         inr;
    inr = (int'(w[14:8]) < MAX_ADDR);
    tx  = (RB && w[15] && inr) ? bus.rd_data_i : 8'h00;
    @(negedge clk) bus.cs_n_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) b = w[15-i];
      else        b = 1'b1;
      bus.mosi_i = b;
      repeat (4) @(negedge clk);
      bus.sclk_i = 1'b1;
      if (i >= 8 && i < 16) chk("miso_bit", {7'd0, bus.miso_o}, {7'd0, tx[15-i]});
      if (i == 7) exp_addr = {1'b0, w[14:8]};
      if (i == 15) begin
        if (!w[15] && inr) begin
          exp_data = w[7:0];
          q.push_back('{1'b1, 1'b0, exp_addr, exp_data, cyc + 4});
        end else if (!inr && (!w[15] || RB)) begin
          q.push_back('{1'b0, 1'b1, exp_addr, exp_data, cyc + 4});
        end
      end
      repeat (8) @(negedge clk);
      bus.sclk_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    bus.cs_n_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("addr_o", bus.addr_o, exp_addr);
    chk("data_o", bus.data_o, exp_data);
    vec++;
    assert (q.size() == 0) else begin
      miscmp++;
      $error("FAIL pulse_missing got %0d pending events expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] w;
    bus.cs_n_i    = 1'b1;
    bus.sclk_i    = 1'b0;
    bus.mosi_i    = 1'b0;
    bus.rd_data_i = 8'hC3;
    repeat (3) @(negedge clk);
    chk("rst_addr",  bus.addr_o, 8'h00);
    chk("rst_data",  bus.data_o, 8'h00);
    chk("rst_wr",    {7'd0, bus.wr_en_o}, 8'h00);
    chk("rst_err",   {7'd0, bus.addr_err_o}, 8'h00);
    chk("rst_miso",  {7'd0, bus.miso_o}, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    frame(16'h01A5, 16);          // basic write
    frame(16'h0A55, 16);          // out of range write
    frame(16'h02FF, 11);          // aborted frame
    frame(16'h023C, 16);
    frame(16'h0700, 16);          // last valid address
    frame(16'h0811, 16);          // first invalid address
    frame(16'h8300, 16);          // read in range
    frame(16'h8A00, 16);          // read out of range
    frame(16'h0412, 20);          // trailing clocks ignored

    // reset during bit 5
    @(negedge clk) bus.cs_n_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.mosi_i = i[0];
      repeat (4) @(negedge clk);
      bus.sclk_i = 1'b1;
      if (i < 5) begin
        repeat (8) @(negedge clk);
        bus.sclk_i = 1'b0;
        repeat (4) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", bus.addr_o, 8'h00);
    chk("midrst_data", bus.data_o, 8'h00);
    chk("midrst_wr",   {7'd0, bus.wr_en_o}, 8'h00);
    chk("midrst_err",  {7'd0, bus.addr_err_o}, 8'h00);
    chk("midrst_miso", {7'd0, bus.miso_o}, 8'h00);
    exp_addr = 8'h00;
    exp_data = 8'h00;
    @(negedge clk);
    bus.sclk_i = 1'b0;
    bus.cs_n_i = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    frame(16'h0001, 16);

    for (int k = 0; k < 6; k++) begin
      bus.rd_data_i = 8'($urandom);
      w = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom)};
      frame(w, 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule

// File: doc/spi_reg_if.md
SPI_REG_IF -- requirements
Module: spi_reg_if

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 8, number of valid register addresses (0..MAX_ADDR-1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for SPI inputs (minimum 2).
REQ-003 SHALL have port clk, input, 1, system clock, the block's only clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sclk_i, input, 1, SPI serial clock (asynchronous to clk, mode 0).
REQ-006 SHALL have port cs_n_i, input, 1, SPI chip select, active low.
REQ-007 SHALL have port mosi_i, input, 1, SPI serial data in.
REQ-008 SHALL have port miso_o, output, 1, SPI serial data out.
REQ-009 SHALL have port addr_o, output, 8, register address to the register file.
REQ-010 SHALL have port data_o, output, 8, register write data.
REQ-011 SHALL have port wr_en_o, output, 1, single-cycle write strobe.
REQ-012 SHALL have port rd_data_i, input, 8, register read-back data for addr_o.
REQ-013 SHALL have port addr_err_o, output, 1, single-cycle pulse on an out-of-range access.

Function
REQ-014 SHALL pass sclk_i, cs_n_i and mosi_i through SYNC_STAGES-flop synchronizers; clk SHALL be at least 8x the sclk_i frequency.
REQ-015 SHALL detect sclk rising/falling edges from the synchronized sclk and its one-cycle-delayed copy.
REQ-016 SHALL sample mosi on each detected rising edge, MSB first; frame = 16 bits: byte0 = {rw, addr[6:0]} (rw 0 = write, 1 = read), byte1 = data.
REQ-017 SHALL implement states IDLE, ADDR, DATA, WAIT_CS: IDLE->ADDR on synchronized cs_n falling; ADDR->DATA after the 8th rising edge; DATA->WAIT_CS after the 16th rising edge; any state->IDLE when synchronized cs_n is high.
REQ-018 SHALL drive addr_o = {1'b0, addr[6:0]} from the end of byte0 and hold it until the next byte0 completes.
REQ-019 On a write frame with addr < MAX_ADDR, SHALL assert wr_en_o for exactly one clk cycle, with data_o = byte1, 3 clk cycles after the first clk edge that samples the 16th sclk_i rising edge high.
REQ-020 On a write frame with addr >= MAX_ADDR, SHALL NOT assert wr_en_o and SHALL pulse addr_err_o for one cycle in the same cycle wr_en_o would have been asserted.
REQ-021 SHALL discard a frame in which cs_n deasserts before the 16th rising edge: no wr_en_o, no addr_err_o, data_o unchanged.
REQ-022 SHALL ignore sclk edges in WAIT_CS and IDLE (extra bits and trailing clocks are dropped).
REQ-023 data_o SHALL hold its last written value between frames.

Reset
REQ-024 On rst_n low (asynchronous): state IDLE; addr_o, data_o = 0; wr_en_o, addr_err_o, miso_o = 0; synchronizers preset to cs_n = 1, sclk = 0, mosi = 0; bit counter = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait in IDLE for a fresh cs_n falling edge.

Configuration
REQ-026 Macro SPI_READBACK_EN defined: on a read frame, rd_data_i SHALL be loaded into the TX shift register in the cycle after the 8th rising edge; miso_o = bit7 immediately, subsequent bits shift on each falling edge in DATA; no wr_en_o for read frames; out-of-range read SHALL return 0x00 and pulse addr_err_o.
REQ-027 Macro SPI_READBACK_EN undefined: miso_o SHALL be constant 0; read frames SHALL produce no wr_en_o and no addr_err_o.

Structure
REQ-028 Package spi_reg_pkg SHALL hold the state enum, FRAME_BITS = 16, ADDR_BITS = 8, RW_BIT = 7.
REQ-029 Synchronizer SHALL be a sub-module sync_ff (parameter STAGES, reset value), instantiated once per SPI input.

Verification
REQ-030 Write frame 0x01,0xA5 -> one wr_en_o pulse, addr_o = 0x01, data_o = 0xA5, 3 clk cycles after the 16th sclk rising edge.
REQ-031 Write frame 0x0A,0x55 (MAX_ADDR = 8) -> no wr_en_o, one addr_err_o pulse, data_o unchanged.
REQ-032 cs_n raised after 11 bits of 0x02,0xFF -> no wr_en_o; next full frame 0x02,0x3C -> write of 0x3C to 0x02.
REQ-033 SPI_READBACK_EN, rd_data_i = 0xC3, frame 0x83,xx -> miso_o bits 1,1,0,0,0,0,1,1 in the data phase; no wr_en_o.
REQ-034 rst_n pulsed low during bit 5 of a frame -> all outputs 0 immediately; next frame 0x00,0x01 -> single write of 0x01 to 0x00.
